// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (2-flop synchroniser, mid-bit sampling) feeding a first-word-fall-through byte FIFO.
// A byte is readable 1 cycle after its stop-bit sample; when the FIFO is full and not popped, the byte is dropped and overrun is set.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 25_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    output logic                        rd_valid,
    output logic [7:0]                  rd_data,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        overrun,
    output logic                        frame_err,
    input  logic                        err_clr
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int OCC_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] DEPTH_CNT = OCC_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             expire;
    logic             push;
    logic             frame_bad;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign expire    = (baud_cnt == '0);
    assign push      = (state == ST_STOP) && expire && rx_s;
    assign frame_bad = (state == ST_STOP) && expire && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        baud_cnt <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DATA;
                            bit_idx  <= '0;
                            baud_cnt <= FULL_LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shreg    <= {rx_s, shreg[7:1]};
                        baud_cnt <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (expire) begin
                        state <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before another frame can start.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid = (rx_count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;
    assign pop      = rd_valid && rd_ready;
    assign full     = (rx_count == DEPTH_CNT);
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rx_count <= rx_count + OCC_W'(push_ok) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // A new error event on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-level receive model checked every cycle, plus literal expectations per scenario.
module tb_uart_rx_fifo;

    localparam int CPB   = 25_000_000 / 115_200;
    localparam int DEPTH = 16;
    localparam int LAT   = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         ok;
    } arr_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       uart_rx  = 1'b1;
    logic       rd_ready = 1'b0;
    logic       err_clr  = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] rx_count;
    logic       overrun;
    logic       frame_err;

    arr_t       pend[$];
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    bit         m_ovr = 1'b0;
    bit         m_fe  = 1'b0;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_p = 0;
    int         last_a = 0;
    int         found  = 0;
    logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    logic [7:0] rb = 8'hC3;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    always #20 clk = ~clk;

    // Model: byte lands at its scheduled stop-sample edge; pop applies before push.
    always @(posedge clk) begin
        bit pop_now;
        bit set_o;
        bit set_f;
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            pend.delete();
            m_ovr = 1'b0;
            m_fe  = 1'b0;
        end else begin
            pop_now = (mq.size() != 0) && rd_ready;
            set_o   = 1'b0;
            set_f   = 1'b0;
            if (pop_now) void'(mq.pop_front());
            if (pend.size() != 0 && pend[0].at == cyc) begin
                if (pend[0].ok) begin
                    if (mq.size() < DEPTH) mq.push_back(pend[0].b);
                    else set_o = 1'b1;
                end else begin
                    set_f = 1'b1;
                end
                void'(pend.pop_front());
            end
            if (set_o) m_ovr = 1'b1;
            else if (err_clr) m_ovr = 1'b0;
            if (set_f) m_fe = 1'b1;
            else if (err_clr) m_fe = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && rd_valid && rd_ready) popped.push_back(rd_data);
    end

    always @(negedge clk) begin
        int         n;
        logic [7:0] head;
        if (!rst) begin
            n    = mq.size();
            head = (n != 0) ? mq[0] : 8'h00;
            checks = checks + 1;
            if (rd_valid !== (n != 0) || int'(rx_count) != n || overrun !== m_ovr ||
                frame_err !== m_fe || (n != 0 && rd_data !== head)) begin
                errors = errors + 1;
                $display("FAIL cycle_cmp cyc=%0d got v=%b d=%h n=%0d o=%b f=%b want v=%b d=%h n=%0d o=%b f=%b",
                         cyc, rd_valid, rd_data, rx_count, overrun, frame_err,
                         (n != 0), head, n, m_ovr, m_fe);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int pv(input int i);
        return (i < popped.size()) ? int'(popped[i]) : -1;
    endfunction

    task automatic bit_hold(input logic v, input int len);
        uart_rx = v;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len, input bit jit);
        arr_t e;
        @(negedge clk);
        last_p = cyc + 1;
        last_a = last_p + LAT;
        e.at = last_a;
        e.b  = b;
        e.ok = stop;
        pend.push_back(e);
        bit_hold(1'b0, CPB - (jit ? 2 : 0));
        for (int i = 0; i < 8; i++) bit_hold(b[i], CPB + (jit ? (i % 5) - 2 : 0));
        bit_hold(stop, stop_len);
        uart_rx = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
        chk({tag, "_rx_count"}, int'(rx_count), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with consumer always ready; rd_valid rises the cycle after the stop sample.
        rd_ready = 1'b1;
        popped.delete();
        fork
            send_byte(8'h48, 1'b1, CPB, 1'b0);
            begin
                for (int k = 0; k < 3000 && !rd_valid; k++) @(negedge clk);
                chk("single_rise_latency", cyc - last_p, 2063);
            end
        join
        repeat (5) @(negedge clk);
        chk("single_pops", popped.size(), 1);
        chk("single_data", pv(0), 8'h48);
        chk("single_overrun", int'(overrun), 0);
        chk("single_frame_err", int'(frame_err), 0);

        // Back-to-back burst with per-bit jitter, drained afterwards.
        rd_ready = 1'b0;
        popped.delete();
        for (int i = 0; i < 5; i++) send_byte(hello[i], 1'b1, CPB, 1'b1);
        repeat (5) @(negedge clk);
        chk("burst_count", int'(rx_count), 5);
        rd_ready = 1'b1;
        repeat (10) @(negedge clk);
        rd_ready = 1'b0;
        chk("burst_drained", int'(rx_count), 0);
        for (int i = 0; i < 5; i++) chk("burst_data", pv(i), int'(hello[i]));

        // Overflow, err_clr, then a push coinciding with a pop while full.
        popped.delete();
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        chk("ovf_count", int'(rx_count), 16);
        chk("ovf_overrun", int'(overrun), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", int'(overrun), 0);
        found = 0;
        fork
            send_byte(8'h11, 1'b1, CPB, 1'b0);
            begin
                repeat (5) @(negedge clk);
                for (int k = 0; k < 3000; k++) begin
                    if (cyc == last_a - 1) begin
                        found = 1;
                        break;
                    end
                    @(negedge clk);
                end
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
            end
        join
        chk("simul_aligned", found, 1);
        repeat (3) @(negedge clk);
        chk("simul_count", int'(rx_count), 16);
        chk("simul_overrun", int'(overrun), 0);
        rd_ready = 1'b1;
        repeat (20) @(negedge clk);
        rd_ready = 1'b0;
        chk("ovf_pops", popped.size(), 17);
        for (int i = 0; i < 16; i++) chk("ovf_data", pv(i), i);
        chk("simul_data", pv(16), 8'h11);

        // Glitch shorter than half a bit, then a real frame.
        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("noise_count", int'(rx_count), 0);
        rd_ready = 1'b1;
        popped.delete();
        send_byte(8'hA5, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        chk("noise_pops", popped.size(), 1);
        chk("noise_data", pv(0), 8'hA5);
        rd_ready = 1'b0;

        // Bad stop bit followed by a held-low line.
        send_byte(8'h3C, 1'b0, 3 * CPB, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("fe_flag", int'(frame_err), 1);
        chk("fe_count", int'(rx_count), 0);
        send_byte(8'h55, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        chk("fe_next_count", int'(rx_count), 1);
        chk("fe_next_data", int'(rd_data), 8'h55);

        // Reset in the middle of data bit 4.
        @(negedge clk);
        bit_hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_hold(rb[i], CPB);
        bit_hold(rb[4], CPB / 2);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (CPB) @(negedge clk);
        rd_ready = 1'b1;
        popped.delete();
        send_byte(8'h7E, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        chk("midrst_pops", popped.size(), 1);
        chk("midrst_data", pv(0), 8'h7E);
        rd_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver with a small receive FIFO. It is the inbound counterpart of the SoC I/O register bank's UART transmitter. It deserialises an 8N1 line into bytes and buffers them, so software (or a bench loopback from uart_tx) can drain them later through a valid/ready read port. It sits between the board RX pin and the I/O register bank.

Parameters:
CLOCK_FREQ, 25_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s; CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer truncation, 217 at defaults)
FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
uart_rx  input  1  serial line, idle high, asynchronous to clk
rd_valid  output  1  FIFO non-empty
rd_data  output  8  FIFO head byte (first-word-fall-through)
rd_ready  input  1  consumer pops head when rd_valid && rd_ready
rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overrun  output  1  sticky: byte dropped because FIFO full
frame_err  output  1  sticky: stop bit sampled low
err_clr  input  1  clears overrun and frame_err

Behaviour:
- Reset (async assert, sync release):
  - rd_valid=0, rd_data=0, rx_count=0, overrun=0, frame_err=0
  - FSM in IDLE; pointers zeroed
  - synchroniser flops preset to 1 (idle line)
- Input path: uart_rx passes through a 2-flop synchroniser; all decoding uses the synchronised bit rx_s.
- FSM states:
  - IDLE -> START on rx_s==0; baud counter loads CLKS_PER_BIT/2 - 1.
  - START: at counter expiry, resample rx_s.
    - rx_s==1: false start, go to IDLE, nothing pushed.
    - rx_s==0: go to DATA; bit index=0; counter loads CLKS_PER_BIT-1.
  - DATA: at each expiry, sample rx_s into the shift register, LSB first. After bit 7 go to STOP; counter reloads CLKS_PER_BIT-1.
  - STOP: at expiry, sample rx_s.
    - 1: push byte, go to IDLE.
    - 0: set frame_err, discard byte, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Timing:
  - Samples fall at mid-bit: start at 0.5 bit-times, data bit n at (1.5+n) bit-times, stop at 9.5 bit-times after the IDLE->START edge.
  - Push happens on the stop-sample edge; rd_valid rises the following cycle.
  - Add 2 cycles of synchroniser latency from the pin.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; occupancy is tracked by rx_count.
  - rd_valid = (rx_count != 0); rd_data = mem[rd_ptr], registered/stable while rd_valid && !rd_ready.
  - Pop: rd_valid && rd_ready. rd_ready while empty has no effect.
  - Push while full with no pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle: both take effect, including when full (no overrun) and when empty-with-push (pop ignored since rd_valid=0). rx_count is unchanged when both succeed.
- Sticky flags: cleared by err_clr on the next edge. If a set event and err_clr coincide, set wins.
- Reset mid-frame: frame abandoned, FIFO emptied. After release, the receiver waits in IDLE for the next falling edge. Reception resumes correctly if the line is idle or at the next start bit.
- Back-to-back frames (stop bit immediately followed by a start bit) are received without loss. Line jitter up to ±2 clk per bit at defaults is tolerated.

Test Plan:
- Single byte: drive 0x48 at 115200 from 25 MHz model, rd_ready=1 -> one pop of rd_data=0x48. rd_valid rises 1 cycle after stop sample; overrun=frame_err=0.
- Burst: send "Hello" back-to-back with rd_ready=0 -> rx_count=5. Then assert rd_ready -> pops 0x48,0x65,0x6C,0x6C,0x6F in order; rx_count=0.
- Overflow: send 17 bytes 0x00..0x10 with rd_ready=0 -> rx_count=16, overrun=1, drained data 0x00..0x0F. Pulse err_clr -> overrun=0.
- Noise/false start: pull line low for 50 cycles (< half bit) -> no push, FSM back to IDLE. Following valid 0xA5 is received correctly.
- Frame error: send 0x3C with stop bit 0 and line held low 3 bit-times -> frame_err=1, rx_count=0, no spurious bytes. Next valid 0x55 is received.
- Full + simultaneous: FIFO full, pop on the same cycle as a push -> rx_count stays 16, overrun=0. Separately, assert rst during bit 4 of a frame -> outputs return to reset values; next byte 0x7E is received intact.
